// File: rtl/alu32_nibble_seq.sv
// alu32_nibble_seq: 32-bit add/subtract built from one shared 4-bit
// carry-lookahead slice. One nibble is processed per cycle, LSB nibble first,
// with a start/busy/done handshake and N/Z/C/V flags.

// 4-bit carry-lookahead adder slice.
// c3 is the carry into bit 3, used for the signed-overflow tap.
module cla4_ov (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       ci,
  output logic [3:0] s,
  output logic       c3,
  output logic       co
);
  logic [3:0] g;
  logic [3:0] p;
  logic [4:0] cy;

  // Generate/propagate terms and two-level lookahead carries.
  always_comb begin
    g     = a & b;
    p     = a ^ b;
    cy[0] = ci;
    cy[1] = g[0] | (p[0] & ci);
    cy[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
    cy[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
          | (p[2] & p[1] & p[0] & ci);
    cy[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
          | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & ci);
    s     = p ^ cy[3:0];
    c3    = cy[3];
    co    = cy[4];
  end
endmodule

module alu32_nibble_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             n,
  output logic             z,
  output logic             c,
  output logic             v
);
  localparam int NNIB  = WIDTH / 4;
  localparam int CNT_W = (NNIB > 1) ? $clog2(NNIB) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NNIB - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             n_q, n_d, z_q, z_d, c_q, c_d, v_q, v_d;

  logic [3:0]       slice_s;
  logic             slice_c3;
  logic             slice_co;
  logic [WIDTH+3:0] sum_ext;

  // The single shared slice always works on the low nibble of A and B.
  cla4_ov u_slice (
    .a  (a_q[3:0]),
    .b  (b_q[3:0]),
    .ci (carry_q),
    .s  (slice_s),
    .c3 (slice_c3),
    .co (slice_co)
  );

  // New sum nibble enters at the top; after NNIB shifts the word is complete.
  assign sum_ext = {slice_s, sum_q};

  // Next-state and datapath control for IDLE -> RUN -> DONE sequencing.
  always_comb begin
    // NOTE: every _d gets its hold value first so no path can infer a latch.
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    sum_d    = sum_q;
    carry_d  = carry_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    n_d      = n_q;
    z_d      = z_q;
    c_d      = c_q;
    v_d      = v_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d     = a;
          // Subtract is a + ~b + 1: invert B here, the +1 is the carry-in.
          b_d     = op ? ~b : b;
          carry_d = op;
          cnt_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        a_d     = a_q >> 4;
        b_d     = b_q >> 4;
        sum_d   = sum_ext[WIDTH+3:4];
        carry_d = slice_co;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          result_d = sum_d;
          n_d      = sum_d[WIDTH-1];
          z_d      = (sum_d == '0);
          c_d      = slice_co;
          v_d      = slice_c3 ^ slice_co;
          state_d  = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      sum_q    <= '0;
      carry_q  <= 1'b0;
      cnt_q    <= '0;
      result_q <= '0;
      n_q      <= 1'b0;
      z_q      <= 1'b0;
      c_q      <= 1'b0;
      v_q      <= 1'b0;
    end else begin
      // NOTE: non-blocking so every register samples pre-edge values.
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      sum_q    <= sum_d;
      carry_q  <= carry_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      n_q      <= n_d;
      z_q      <= z_d;
      c_q      <= c_d;
      v_q      <= v_d;
    end
  end

  assign busy   = (state_q == S_RUN);
  assign done   = (state_q == S_DONE);
  assign result = result_q;
  assign n      = n_q;
  assign z      = z_q;
  assign c      = c_q;
  assign v      = v_q;
endmodule

// File: tb/tb_alu32_nibble_seq.sv
// Self-checking bench for alu32_nibble_seq: directed corner cases, ignored
// starts, reset mid-operation and random operations against a word-level model.
module tb_alu32_nibble_seq;
  localparam int W = 32;
  localparam int LAT = 8;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         start = 1'b0;
  logic         op = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy, done, n, z, c, v;
  logic [W-1:0] result;

  int pass_cnt = 0;
  int total_cnt = 0;

  alu32_nibble_seq #(.WIDTH(W)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .result(result), .n(n), .z(z), .c(c), .v(v)
  );

  always #5 clk = ~clk;

  // Word-level reference: returns {result, n, z, c, v}.
  function automatic logic [W+3:0] ref_model(input logic o, input logic [W-1:0] x,
                                             input logic [W-1:0] y);
    logic [W:0]   full;
    logic [W-1:0] r;
    logic         cf, vf;
    if (o) full = {1'b0, x} + {1'b0, ~y} + 1;
    else   full = {1'b0, x} + {1'b0, y};
    r  = full[W-1:0];
    cf = full[W];
    if (o) vf = (x[W-1] != y[W-1]) && (r[W-1] != x[W-1]);
    else   vf = (x[W-1] == y[W-1]) && (r[W-1] != x[W-1]);
    return {r, r[W-1], (r == '0), cf, vf};
  endfunction

  // Issue one operation and check acceptance, latency, result, flags, pulse.
  task automatic do_op(input string name, input logic o, input logic [W-1:0] x,
                       input logic [W-1:0] y);
    logic [W+3:0] exp_v;
    int           cyc;
    exp_v = ref_model(o, x, y);
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    @(negedge clk);
    start = 1'b0; op = $urandom; a = $urandom; b = $urandom;
    total_cnt++;
    if (busy !== 1'b1) $display("FAIL %s busy after accept: got %b want 1", name, busy);
    else pass_cnt++;
    cyc = 0;
    while (done !== 1'b1 && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    total_cnt++;
    if (cyc !== LAT) $display("FAIL %s latency: got %0d want %0d", name, cyc, LAT);
    else pass_cnt++;
    total_cnt++;
    if ({result, n, z, c, v} !== exp_v)
      $display("FAIL %s result/nzcv: got %h %b%b%b%b want %h %b", name, result,
               n, z, c, v, exp_v[W+3:4], exp_v[3:0]);
    else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if ({done, busy, result} !== {2'b00, exp_v[W+3:4]})
      $display("FAIL %s after done: got done=%b busy=%b res=%h want 0 0 %h", name,
               done, busy, result, exp_v[W+3:4]);
    else pass_cnt++;
  endtask

  task automatic test_reset();
    #2;
    total_cnt++;
    if ({busy, done, result, n, z, c, v} !== '0)
      $display("FAIL reset outputs: got %b%b %h %b%b%b%b want all 0", busy, done,
               result, n, z, c, v);
    else pass_cnt++;
    @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    total_cnt++;
    if ({busy, done} !== 2'b00) $display("FAIL idle after reset: got busy=%b done=%b want 0 0", busy, done);
    else pass_cnt++;
  endtask

  task automatic test_directed();
    do_op("add_ovf",  1'b0, 32'h7FFF_FFFF, 32'h0000_0001);
    do_op("add_wrap", 1'b0, 32'hFFFF_FFFF, 32'h0000_0001);
    do_op("sub_eq",   1'b1, 32'h0000_0005, 32'h0000_0005);
    do_op("sub_ovf",  1'b1, 32'h8000_0000, 32'h0000_0001);
    do_op("sub_borrow", 1'b1, 32'h0000_0001, 32'h0000_0002);
  endtask

  task automatic test_ignored_start();
    int dones;
    @(negedge clk);
    start = 1'b1; op = 1'b0; a = 32'd3; b = 32'd4;
    @(negedge clk);
    start = 1'b0;
    dones = 0;
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      if (done === 1'b1) dones++;
      if (k == 3) begin start = 1'b1; op = 1'b1; a = '1; b = '1; end
      else if (k == 4) start = 1'b0;
      else if (k == LAT) begin start = 1'b1; op = 1'b0; a = '1; b = '1; end
      else if (k == 9) begin start = 1'b1; op = 1'b1; a = 32'd100; b = 32'd58; end
    end
    total_cnt++;
    if (dones !== 1) $display("FAIL ign_single_done: got %0d dones want 1", dones);
    else pass_cnt++;
    total_cnt++;
    if ({result, n, z, c, v} !== ref_model(1'b0, 32'd3, 32'd4))
      $display("FAIL ign_result: got %h want %h", result, 32'd7);
    else pass_cnt++;
    @(negedge clk);
    start = 1'b0;
    total_cnt++;
    if (busy !== 1'b1) $display("FAIL ign_next_accept busy: got %b want 1", busy);
    else pass_cnt++;
    repeat (LAT) @(negedge clk);
    total_cnt++;
    if ({done, result, n, z, c, v} !== {1'b1, ref_model(1'b1, 32'd100, 32'd58)})
      $display("FAIL ign_next_result: got done=%b %h want 1 %h", done, result, 32'd42);
    else pass_cnt++;
    @(negedge clk);
  endtask

  task automatic test_reset_mid_op();
    int dones;
    @(negedge clk);
    start = 1'b1; op = 1'b0; a = 32'h1234_5678; b = 32'h1111_1111;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    #1 reset_n = 1'b0;
    #1;
    total_cnt++;
    if ({busy, done, result, n, z, c, v} !== '0)
      $display("FAIL midrst outputs: got %b%b %h %b%b%b%b want all 0", busy, done,
               result, n, z, c, v);
    else pass_cnt++;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    dones = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) dones++;
    end
    total_cnt++;
    if (dones !== 0) $display("FAIL midrst no_activity: got %0d busy/done cycles want 0", dones);
    else pass_cnt++;
    do_op("post_rst_add", 1'b0, 32'd1, 32'd2);
  endtask

  task automatic test_random();
    logic [W-1:0] x, y;
    logic         o;
    for (int i = 0; i < 16; i++) begin
      x = $urandom; y = $urandom; o = 1'($urandom_range(0, 1));
      if (i % 4 == 0) y = x;
      do_op("random", o, x, y);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_ignored_start();
    test_reset_mid_op();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end
endmodule
